// File: rtl/get_bit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : get_bit_pkg
//  Description : Shared encoder configuration constants. The bit reader
//                (get_bit) takes its buffer geometry from here, next to the
//                constants used by the bit packer on the write side.
//  Revision    : 1.0 - initial release
// ============================================================================
package get_bit_pkg;

    // Bit reader geometry
    localparam int GB_BUF_BITS = 128;   // bit-buffer capacity
    localparam int GB_MAX_RD   = 32;    // widest single extraction
    localparam int GB_IN_W     = 64;    // input word width (8 packed bytes)
    localparam int GB_FILL_W   = 8;     // width of fill counter
    localparam int GB_OFS_W    = 64;    // width of the consumed-bit counter

    // Bit packer geometry (write side of the same encoder)
    localparam int PK_OUT_W    = 64;    // packer output word width
    localparam int PK_MAX_WR   = 32;    // widest single packer write

    // Number of bits needed to reach the next byte boundary from a bit offset.
    function automatic logic [2:0] bits_to_byte_boundary(input logic [2:0] ofs_lsb);
        return 3'd0 - ofs_lsb;
    endfunction

endpackage : get_bit_pkg
`default_nettype wire

// File: rtl/get_bit.sv
`default_nettype none
// ============================================================================
//  Module      : get_bit
//  Description : Bit-stream reader. Byte words are appended MSB-first into a
//                left-justified bit buffer; reads extract the top rd_size
//                bits (registered, latency 1) and shift the buffer left.
//                An align request discards bits up to the next byte boundary
//                of the consumed-bit offset.
//  Ports       : clock/reset_n     - clock, synchronous active-high reset
//                in_valid/in_data/in_bytes/in_ready - input byte word
//                rd_en/rd_size/align/rd_ready       - read / align request
//                rd_valid/rd_val   - registered read result
//                peek_val          - next 32 unconsumed bits, left-justified
//                fill_bits         - unconsumed bits held
//                bit_offset        - total bits consumed since reset
//  Revision    : 1.0 - initial release
// ============================================================================
module get_bit
    import get_bit_pkg::*;
#(
    parameter int BUF_BITS = GB_BUF_BITS,
    parameter int MAX_RD   = GB_MAX_RD
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [GB_IN_W-1:0]   in_data,
    input  logic [3:0]           in_bytes,
    output logic                 in_ready,
    input  logic                 rd_en,
    input  logic [5:0]           rd_size,
    input  logic                 align,
    output logic                 rd_ready,
    output logic                 rd_valid,
    output logic [MAX_RD-1:0]    rd_val,
    output logic [31:0]          peek_val,
    output logic [GB_FILL_W-1:0] fill_bits,
    output logic [GB_OFS_W-1:0]  bit_offset
);

    localparam logic [GB_FILL_W-1:0] c_in_limit = GB_FILL_W'(BUF_BITS - GB_IN_W);

    // Registered state. Invariant: every buffer bit below the fill is zero,
    // which keeps peek_val zero-padded and lets appends be a simple OR.
    logic [BUF_BITS-1:0]  bits_q,     bits_d;
    logic [GB_FILL_W-1:0] fill_q,     fill_d;
    logic [GB_OFS_W-1:0]  offset_q,   offset_d;
    logic [MAX_RD-1:0]    rd_val_q,   rd_val_d;
    logic                 rd_valid_q, rd_valid_d;

    logic                 w_rd_take;
    logic                 w_in_take;
    logic                 w_align_take;
    logic [3:0]           w_in_len;
    logic [GB_FILL_W-1:0] w_align_amt;
    logic [GB_FILL_W-1:0] w_cons;
    logic [GB_FILL_W-1:0] w_fill_kept;
    logic [GB_IN_W-1:0]   w_in_mask;
    logic [BUF_BITS-1:0]  w_kept;
    logic [BUF_BITS-1:0]  w_appended;
    logic [MAX_RD-1:0]    w_top;

    assign in_ready   = (fill_q <= c_in_limit);
    assign rd_ready   = (fill_q >= GB_FILL_W'(rd_size));
    assign rd_valid   = rd_valid_q;
    assign rd_val     = rd_val_q;
    assign peek_val   = bits_q[BUF_BITS-1 -: 32];
    assign fill_bits  = fill_q;
    assign bit_offset = offset_q;

    always_comb begin
        w_rd_take    = rd_en && rd_ready;
        w_in_take    = in_valid && in_ready && (in_bytes != 4'd0);
        w_align_take = align && !rd_en;

        // Out-of-range byte counts saturate to a full word so the fill can
        // never exceed the buffer.
        w_in_len = (in_bytes > 4'd8) ? 4'd8 : in_bytes;

        // An align cannot discard bits that have not arrived yet.
        w_align_amt = GB_FILL_W'(bits_to_byte_boundary(offset_q[2:0]));
        if (w_align_amt > fill_q) begin
            w_align_amt = fill_q;
        end

        w_cons = '0;
        if (w_rd_take) begin
            w_cons = GB_FILL_W'(rd_size);
        end else if (w_align_take) begin
            w_cons = w_align_amt;
        end

        // Consumption first, then the new word lands right after what is
        // left; read data always comes from the pre-append contents.
        w_kept      = bits_q << w_cons;
        w_fill_kept = fill_q - w_cons;
        w_in_mask   = ~({GB_IN_W{1'b1}} >> {w_in_len, 3'b000});
        w_appended  = {in_data & w_in_mask, {(BUF_BITS - GB_IN_W){1'b0}}} >> w_fill_kept;

        bits_d   = w_kept;
        fill_d   = w_fill_kept;
        if (w_in_take) begin
            bits_d = w_kept | w_appended;
            fill_d = w_fill_kept + GB_FILL_W'({w_in_len, 3'b000});
        end
        offset_d = offset_q + GB_OFS_W'(w_cons);

        // Right-justify the top rd_size bits; a zero-size read shifts by the
        // full width and yields zero.
        w_top      = bits_q[BUF_BITS-1 -: MAX_RD];
        rd_val_d   = rd_val_q;
        rd_valid_d = w_rd_take;
        if (w_rd_take) begin
            rd_val_d = w_top >> (7'(MAX_RD) - {1'b0, rd_size});
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            bits_q     <= '0;
            fill_q     <= '0;
            offset_q   <= '0;
            rd_val_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            bits_q     <= bits_d;
            fill_q     <= fill_d;
            offset_q   <= offset_d;
            rd_val_q   <= rd_val_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule : get_bit
`default_nettype wire

// File: tb/tb_get_bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_get_bit
//  Description : Directed self-checking bench for get_bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_get_bit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_bytes;
    logic        in_ready;
    logic        rd_en;
    logic [5:0]  rd_size;
    logic        align;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_val;
    logic [31:0] peek_val;
    logic [7:0]  fill_bits;
    logic [63:0] bit_offset;

    int n_checks = 0;
    int n_errors = 0;

    get_bit dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_bytes   (in_bytes),
        .in_ready   (in_ready),
        .rd_en      (rd_en),
        .rd_size    (rd_size),
        .align      (align),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_val     (rd_val),
        .peek_val   (peek_val),
        .fill_bits  (fill_bits),
        .bit_offset (bit_offset)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle away from the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [63:0] d, input logic [3:0] n);
        in_valid = 1'b1;
        in_data  = d;
        in_bytes = n;
        cyc();
        in_valid = 1'b0;
        in_bytes = 4'd0;
    endtask

    task automatic do_read(input logic [5:0] n);
        rd_en   = 1'b1;
        rd_size = n;
        cyc();
        rd_en   = 1'b0;
    endtask

    task automatic do_align();
        align = 1'b1;
        cyc();
        align = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_bytes = 4'd0;
        rd_en    = 1'b0;
        rd_size  = 6'd0;
        align    = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b0;

        // Reset state
        chk("rst_fill",     {56'd0, fill_bits}, 64'd0);
        chk("rst_offset",   bit_offset, 64'd0);
        chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("rst_rd_val",   {32'd0, rd_val}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_rd_rdy0",  {63'd0, rd_ready}, 64'd1);
        rd_size = 6'd5;
        #1;
        chk("rst_rd_rdy5",  {63'd0, rd_ready}, 64'd0);

        // Two-byte word, read 4 then 12
        do_load(64'hA5C3_0000_0000_0000, 4'd2);
        chk("ld2_fill", {56'd0, fill_bits}, 64'd16);
        chk("ld2_peek", {32'd0, peek_val}, 64'hA5C3_0000);
        do_read(6'd4);
        chk("r4_valid", {63'd0, rd_valid}, 64'd1);
        chk("r4_val",   {32'd0, rd_val}, 64'hA);
        chk("r4_fill",  {56'd0, fill_bits}, 64'd12);
        do_read(6'd12);
        chk("r12_val",  {32'd0, rd_val}, 64'h5C3);
        chk("r12_fill", {56'd0, fill_bits}, 64'd0);
        chk("r12_ofs",  bit_offset, 64'd16);
        cyc();
        chk("idle_valid", {63'd0, rd_valid}, 64'd0);
        chk("idle_hold",  {32'd0, rd_val}, 64'h5C3);

        // Unsatisfiable read is dropped
        do_load(64'hC000_0000_0000_0000, 4'd1);
        do_read(6'd6);
        chk("r6_val",  {32'd0, rd_val}, 64'h30);
        chk("r6_fill", {56'd0, fill_bits}, 64'd2);
        rd_size = 6'd3;
        #1;
        chk("r3_ready", {63'd0, rd_ready}, 64'd0);
        do_read(6'd3);
        chk("r3_valid", {63'd0, rd_valid}, 64'd0);
        chk("r3_fill",  {56'd0, fill_bits}, 64'd2);
        chk("r3_ofs",   bit_offset, 64'd22);
        do_align();
        chk("al22_fill", {56'd0, fill_bits}, 64'd0);
        chk("al22_ofs",  bit_offset, 64'd24);

        // Back-pressure at 72 bits
        do_load(64'h0123_4567_89AB_CDEF, 4'd8);
        chk("ld8_fill",  {56'd0, fill_bits}, 64'd64);
        chk("ld8_ready", {63'd0, in_ready}, 64'd1);
        do_load(64'h5500_0000_0000_0000, 4'd1);
        chk("ld72_fill",  {56'd0, fill_bits}, 64'd72);
        chk("ld72_ready", {63'd0, in_ready}, 64'd0);
        do_load(64'hAA00_0000_0000_0000, 4'd1);
        chk("ld_blocked", {56'd0, fill_bits}, 64'd72);
        do_read(6'd8);
        chk("bp_r8_val",   {32'd0, rd_val}, 64'h01);
        chk("bp_r8_fill",  {56'd0, fill_bits}, 64'd64);
        chk("bp_r8_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_peek",     {32'd0, peek_val}, 64'h2345_6789);
        do_read(6'd32);
        chk("r32a_val", {32'd0, rd_val}, 64'h2345_6789);
        do_read(6'd32);
        chk("r32b_val",  {32'd0, rd_val}, 64'hABCD_EF55);
        chk("r32b_fill", {56'd0, fill_bits}, 64'd0);
        chk("r32b_ofs",  bit_offset, 64'd96);

        // Align after a 3-bit read
        do_load(64'hFF00_0000_0000_0000, 4'd1);
        do_read(6'd3);
        chk("ff_r3_val", {32'd0, rd_val}, 64'h7);
        do_align();
        chk("al_fill", {56'd0, fill_bits}, 64'd0);
        chk("al_ofs",  bit_offset, 64'd104);
        do_align();
        chk("al2_fill", {56'd0, fill_bits}, 64'd0);
        chk("al2_ofs",  bit_offset, 64'd104);

        // Zero-size read
        do_read(6'd0);
        chk("r0_valid", {63'd0, rd_valid}, 64'd1);
        chk("r0_val",   {32'd0, rd_val}, 64'd0);
        chk("r0_ofs",   bit_offset, 64'd104);

        // Simultaneous read and append
        do_load(64'h8100_0000_0000_0000, 4'd1);
        in_valid = 1'b1;
        in_data  = 64'h7E00_0000_0000_0000;
        in_bytes = 4'd1;
        do_read(6'd8);
        in_valid = 1'b0;
        in_bytes = 4'd0;
        chk("sim_val",  {32'd0, rd_val}, 64'h81);
        chk("sim_fill", {56'd0, fill_bits}, 64'd8);
        chk("sim_peek", {32'd0, peek_val}, 64'h7E00_0000);

        // Read wins over align in the same cycle
        do_read(6'd1);
        chk("r1_val", {32'd0, rd_val}, 64'd0);
        align = 1'b1;
        do_read(6'd2);
        align = 1'b0;
        chk("ra_val",  {32'd0, rd_val}, 64'h3);
        chk("ra_fill", {56'd0, fill_bits}, 64'd5);
        chk("ra_ofs",  bit_offset, 64'd115);

        // in_bytes = 0 is no transfer
        do_load(64'hFFFF_FFFF_FFFF_FFFF, 4'd0);
        chk("nb0_fill", {56'd0, fill_bits}, 64'd5);

        // Reset mid-stream with fill 40 and a read pending
        do_read(6'd5);
        do_load(64'h1122_3344_5500_0000, 4'd5);
        chk("pre_rst_fill", {56'd0, fill_bits}, 64'd40);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_bytes = 4'd1;
        do_read(6'd8);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_bytes = 4'd0;
        chk("mrst_fill",  {56'd0, fill_bits}, 64'd0);
        chk("mrst_valid", {63'd0, rd_valid}, 64'd0);
        chk("mrst_ofs",   bit_offset, 64'd0);
        chk("mrst_ready", {63'd0, in_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_get_bit
`default_nettype wire
